// File: rtl/mux16_rr_sched_if.sv
// Handshake bundle between the requesters and the 16:1 mux scheduler.
// master drives req/done; slave (the scheduler) returns the select and grant.
interface mux16_rr_sched_if #(
  parameter int CNT_W = 8
);
  logic [15:0]      req;
  logic             done;
  logic [3:0]       sel;
  logic [15:0]      gnt;
  logic             gnt_valid;
  logic [CNT_W-1:0] busy_cnt;

  modport master (
    output req, done,
    input  sel, gnt, gnt_valid, busy_cnt
  );

  modport slave (
    input  req, done,
    output sel, gnt, gnt_valid, busy_cnt
  );
endinterface

// File: rtl/mux16_rr_sched.sv
// Round-robin owner of a shared 16:1 mux; registered grant one edge after req.
// Tenure ends on done, holder withdrawal or hold timeout, always followed by one idle cycle.
module mux16_rr_sched #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  mux16_rr_sched_if.slave    bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [3:0]       sel_q, sel_d;
  logic [15:0]      gnt_q, gnt_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] busy_q, busy_d;

  logic [3:0]       cand;
  logic [3:0]       pick;
  logic             found;
  logic             rel;

  // Walk offsets high to low so the nearest set bit at or after ptr wins.
  always_comb begin
    cand  = '0;
    pick  = ptr_q;
    found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      cand = ptr_q + 4'(i);
      if (bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign rel = bus.done || !bus.req[sel_q] || ((MAX_HOLD != 0) && (busy_q == HOLD_LAST));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = pick;
          gnt_d   = 16'h0001 << pick;
          vld_d   = 1'b1;
          busy_d  = '0;
        end
      end
      GRANT: begin
        // sel and busy_cnt freeze on release so the mux output stays put while idle.
        if (rel) begin
          state_d = IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
          ptr_d   = sel_q + 4'd1;
        end else if (busy_q != '1) begin
          busy_d = busy_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = vld_q;
  assign bus.busy_cnt  = busy_q;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed bench for mux16_rr_sched: vector table for arbitration order, plus
// hand sequences for async reset, hold timeout and coincident release events.
module tb_mux16_rr_sched;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mux16_rr_sched_if #(.CNT_W(8)) bus ();

  mux16_rr_sched #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        vld;
    logic [7:0]  busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [15:0] r, logic d, logic [3:0] s, logic [15:0] g, logic v, logic [7:0] b);
    vec_t x;
    x.req = r; x.done = d; x.sel = s; x.gnt = g; x.vld = v; x.busy = b;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(string tag, logic [3:0] s, logic [15:0] g, logic v, logic [7:0] b);
    chk({tag, " sel"}, 32'(bus.sel), 32'(s));
    chk({tag, " gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, " gnt_valid"}, 32'(bus.gnt_valid), 32'(v));
    chk({tag, " busy_cnt"}, 32'(bus.busy_cnt), 32'(b));
    chk({tag, " vld_eq_or_gnt"}, 32'(bus.gnt_valid), 32'(|bus.gnt));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step(logic [15:0] r, logic d);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    bus.req  = 16'($urandom);
    bus.done = 1'($urandom_range(0, 1));

    // Reset values appear before any clock edge.
    #2;
    expect_out("rst_noclk", 4'd0, 16'h0000, 1'b0, 8'd0);
    for (int i = 0; i < 2; i++) begin
      step(16'($urandom) | 16'h0001, 1'($urandom_range(0, 1)));
      expect_out($sformatf("rst_held%0d", i), 4'd0, 16'h0000, 1'b0, 8'd0);
    end
    bus.req  = 16'h0000;
    bus.done = 1'b0;
    rst      = 1'b0;
    step(16'h0000, 1'b0);
    expect_out("post_rst_a", 4'd0, 16'h0000, 1'b0, 8'd0);
    step(16'h0000, 1'b0);
    expect_out("post_rst_b", 4'd0, 16'h0000, 1'b0, 8'd0);

    // Alternating pair 0/15 with done on the first grant cycle; then done in IDLE.
    tbl.push_back(mk(16'h8001, 1'b0, 4'd0,  16'h0001, 1'b1, 8'd0));
    tbl.push_back(mk(16'h8001, 1'b1, 4'd0,  16'h0000, 1'b0, 8'd0));
    tbl.push_back(mk(16'h8001, 1'b0, 4'd15, 16'h8000, 1'b1, 8'd0));
    tbl.push_back(mk(16'h8001, 1'b1, 4'd15, 16'h0000, 1'b0, 8'd0));
    tbl.push_back(mk(16'h8001, 1'b0, 4'd0,  16'h0001, 1'b1, 8'd0));
    tbl.push_back(mk(16'h8001, 1'b1, 4'd0,  16'h0000, 1'b0, 8'd0));
    tbl.push_back(mk(16'h8001, 1'b0, 4'd15, 16'h8000, 1'b1, 8'd0));
    tbl.push_back(mk(16'h8001, 1'b1, 4'd15, 16'h0000, 1'b0, 8'd0));
    tbl.push_back(mk(16'h0000, 1'b1, 4'd15, 16'h0000, 1'b0, 8'd0));
    tbl.push_back(mk(16'h0000, 1'b0, 4'd15, 16'h0000, 1'b0, 8'd0));
    // Single requester 5: counting, done release, re-grant, withdrawal, done+withdraw.
    tbl.push_back(mk(16'h0020, 1'b0, 4'd5,  16'h0020, 1'b1, 8'd0));
    tbl.push_back(mk(16'h0020, 1'b0, 4'd5,  16'h0020, 1'b1, 8'd1));
    tbl.push_back(mk(16'h0020, 1'b0, 4'd5,  16'h0020, 1'b1, 8'd2));
    tbl.push_back(mk(16'h0020, 1'b1, 4'd5,  16'h0000, 1'b0, 8'd2));
    tbl.push_back(mk(16'h0020, 1'b0, 4'd5,  16'h0020, 1'b1, 8'd0));
    tbl.push_back(mk(16'h0000, 1'b0, 4'd5,  16'h0000, 1'b0, 8'd0));
    tbl.push_back(mk(16'h0020, 1'b0, 4'd5,  16'h0020, 1'b1, 8'd0));
    tbl.push_back(mk(16'h0000, 1'b1, 4'd5,  16'h0000, 1'b0, 8'd0));
    // Move ptr to 2, then all 16 requesting: 2 drops, 3 next, then 4; non-holders ignored.
    tbl.push_back(mk(16'h0002, 1'b0, 4'd1,  16'h0002, 1'b1, 8'd0));
    tbl.push_back(mk(16'h0002, 1'b1, 4'd1,  16'h0000, 1'b0, 8'd0));
    tbl.push_back(mk(16'hFFFF, 1'b0, 4'd2,  16'h0004, 1'b1, 8'd0));
    tbl.push_back(mk(16'hFFFF, 1'b0, 4'd2,  16'h0004, 1'b1, 8'd1));
    tbl.push_back(mk(16'hFFFB, 1'b0, 4'd2,  16'h0000, 1'b0, 8'd1));
    tbl.push_back(mk(16'hFFFF, 1'b0, 4'd3,  16'h0008, 1'b1, 8'd0));
    tbl.push_back(mk(16'hFFFF, 1'b1, 4'd3,  16'h0000, 1'b0, 8'd0));
    tbl.push_back(mk(16'hFFFF, 1'b0, 4'd4,  16'h0010, 1'b1, 8'd0));
    tbl.push_back(mk(16'h0010, 1'b0, 4'd4,  16'h0010, 1'b1, 8'd1));
    tbl.push_back(mk(16'h0011, 1'b1, 4'd4,  16'h0000, 1'b0, 8'd1));
    tbl.push_back(mk(16'h0011, 1'b0, 4'd0,  16'h0001, 1'b1, 8'd0));
    tbl.push_back(mk(16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 8'd0));

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].done);
      expect_out($sformatf("vec%0d", i), tbl[i].sel, tbl[i].gnt, tbl[i].vld, tbl[i].busy);
    end

    // Timeout: requester 3 alone holds exactly 8 cycles, one bubble, then re-grant.
    step(16'h0008, 1'b0);
    expect_out("to_grant", 4'd3, 16'h0008, 1'b1, 8'd0);
    for (int i = 1; i < 8; i++) begin
      step(16'h0008, 1'b0);
      expect_out($sformatf("to_hold%0d", i), 4'd3, 16'h0008, 1'b1, 8'(i));
    end
    step(16'h0008, 1'b0);
    expect_out("to_release", 4'd3, 16'h0000, 1'b0, 8'd7);
    step(16'h0008, 1'b0);
    expect_out("to_regrant", 4'd3, 16'h0008, 1'b1, 8'd0);
    for (int i = 1; i < 8; i++) step(16'h0008, 1'b0);
    expect_out("to_hold7b", 4'd3, 16'h0008, 1'b1, 8'd7);
    // done coincident with timeout: ptr must advance to 4, not 5, so 4 beats 3.
    step(16'h0008, 1'b1);
    expect_out("to_done_rel", 4'd3, 16'h0000, 1'b0, 8'd7);
    step(16'h0018, 1'b0);
    expect_out("to_ptr_once", 4'd4, 16'h0010, 1'b1, 8'd0);
    step(16'h0000, 1'b0);
    expect_out("to_drop", 4'd4, 16'h0000, 1'b0, 8'd0);

    // Async reset in the middle of requester 9's tenure.
    step(16'h0200, 1'b0);
    expect_out("r9_grant", 4'd9, 16'h0200, 1'b1, 8'd0);
    step(16'h0200, 1'b0);
    expect_out("r9_hold", 4'd9, 16'h0200, 1'b1, 8'd1);
    #3 rst = 1'b1;
    #1;
    expect_out("r9_async_rst", 4'd0, 16'h0000, 1'b0, 8'd0);
    #1 rst = 1'b0;
    step(16'h0201, 1'b0);
    expect_out("r9_ptr0", 4'd0, 16'h0001, 1'b1, 8'd0);
    step(16'h0201, 1'b1);
    expect_out("r9_rel0", 4'd0, 16'h0000, 1'b0, 8'd0);
    step(16'h0201, 1'b0);
    expect_out("r9_then9", 4'd9, 16'h0200, 1'b1, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
